// File: rtl/pwm_capture_pkg.sv
// ---------------------------------------------------------------------------
// pwm_capture_pkg
// Shared PWM package: default measurement width, the derived width/MAX
// constants, and the IDLE/HIGH/LOW state encoding. The PWM generator uses the
// same encoding, so both blocks agree on what a "period" is.
// Ports: none (package).
// ---------------------------------------------------------------------------
package pwm_capture_pkg;

    localparam int BITS_DUTY_DEFAULT   = 5;
    localparam int MEAS_WIDTH_DEFAULT  = BITS_DUTY_DEFAULT + 1;
    localparam int MEAS_MAX_DEFAULT    = (1 << MEAS_WIDTH_DEFAULT) - 1;
    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        PWM_IDLE = 2'd0,
        PWM_HIGH = 2'd1,
        PWM_LOW  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// ---------------------------------------------------------------------------
// pwm_capture_if
// Bundles the waveform input and the measurement results of pwm_capture.
//   pwm_in     : asynchronous PWM waveform (driven by master)
//   duty_out   : high time of the last complete period, in clk cycles
//   period_out : rise-to-rise time of the last complete period, in clk cycles
//   valid      : one-cycle pulse when duty_out/period_out update
//   timeout    : sticky, no rising edge seen within MAX cycles
//   level      : synchronized pwm_in level
// Modports: master (stimulus/consumer side), slave (pwm_capture side).
// ---------------------------------------------------------------------------
interface pwm_capture_if
    import pwm_capture_pkg::*;
#(
    parameter int BITS_duty = BITS_DUTY_DEFAULT
);

    logic                 pwm_in;
    logic [BITS_duty:0]   duty_out;
    logic [BITS_duty:0]   period_out;
    logic                 valid;
    logic                 timeout;
    logic                 level;

    modport master (
        output pwm_in,
        input  duty_out,
        input  period_out,
        input  valid,
        input  timeout,
        input  level
    );

    modport slave (
        input  pwm_in,
        output duty_out,
        output period_out,
        output valid,
        output timeout,
        output level
    );

endinterface

// File: rtl/pwm_sync_edge.sv
// ---------------------------------------------------------------------------
// pwm_sync_edge
// Brings an asynchronous input into the clk domain through a SYNC_STAGES-deep
// flop chain, follows it with one delay flop, and produces single-cycle
// rise/fall pulses from the synchronized value against the delayed one.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   async_in : raw asynchronous input
//   level    : synchronized level (last synchronizer stage)
//   rise     : one-cycle pulse, synchronized level went 0 -> 1
//   fall     : one-cycle pulse, synchronized level went 1 -> 0
// SYNC_STAGES must be at least 2 for metastability protection.
// ---------------------------------------------------------------------------
module pwm_sync_edge
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   delay_q, delay_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Edge pulses are registered so the capture FSM only ever sees flop
    // outputs; this adds one cycle of latency in front of every decision.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
        delay_d = sync_q[SYNC_STAGES-1];
        rise_d  = sync_q[SYNC_STAGES-1] & ~delay_q;
        fall_d  = ~sync_q[SYNC_STAGES-1] & delay_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            delay_q <= delay_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
// Measures an asynchronous PWM waveform: high time and rise-to-rise period in
// clk cycles, reported once per complete period with a one-cycle valid pulse.
// A period that reaches MAX = 2^(BITS_duty+1)-1 cycles without a new rising
// edge sets a sticky timeout and returns to IDLE; the last good measurement
// is kept on the outputs.
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-high reset
//   bus : pwm_capture_if.slave (pwm_in in; duty_out, period_out, valid,
//         timeout, level out)
// ---------------------------------------------------------------------------
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int BITS_duty   = BITS_DUTY_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    pwm_capture_if.slave   bus
);

    localparam int           W   = BITS_duty + 1;
    localparam logic [W-1:0] MAX = {W{1'b1}};
    localparam logic [W-1:0] ONE = W'(1);

    logic sync_level;
    logic rise;
    logic fall;

    pwm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.pwm_in),
        .level    (sync_level),
        .rise     (rise),
        .fall     (fall)
    );

    pwm_state_e   state_q, state_d;
    logic [W-1:0] period_cnt_q, period_cnt_d;
    logic [W-1:0] high_cnt_q, high_cnt_d;
    logic [W-1:0] duty_q, duty_d;
    logic [W-1:0] period_q, period_d;
    logic         valid_q, valid_d;
    logic         timeout_q, timeout_d;

    // Next-state and counter logic. The period counter counts every cycle
    // from a rise, the high counter only while HIGH, so a measurement can
    // never report duty above period. Saturation is checked before a normal
    // increment, so the period counter tops out at MAX instead of wrapping;
    // a rise arriving in the saturation cycle still takes the LOW branch
    // first and yields a valid measurement of exactly MAX.
    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        duty_d       = duty_q;
        period_d     = period_q;
        valid_d      = 1'b0;
        timeout_d    = timeout_q;

        unique case (state_q)
            PWM_IDLE: begin
                if (rise) begin
                    state_d      = PWM_HIGH;
                    period_cnt_d = ONE;
                    high_cnt_d   = ONE;
                end
            end

            PWM_HIGH: begin
                if (period_cnt_q == MAX) begin
                    state_d   = PWM_IDLE;
                    timeout_d = 1'b1;
                end else if (fall) begin
                    state_d      = PWM_LOW;
                    period_cnt_d = period_cnt_q + ONE;
                end else begin
                    period_cnt_d = period_cnt_q + ONE;
                    high_cnt_d   = (high_cnt_q == MAX) ? MAX : high_cnt_q + ONE;
                end
            end

            PWM_LOW: begin
                if (rise) begin
                    state_d      = PWM_HIGH;
                    duty_d       = high_cnt_q;
                    period_d     = period_cnt_q;
                    valid_d      = 1'b1;
                    timeout_d    = 1'b0;
                    period_cnt_d = ONE;
                    high_cnt_d   = ONE;
                end else if (period_cnt_q == MAX) begin
                    state_d   = PWM_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    period_cnt_d = period_cnt_q + ONE;
                end
            end

            default: begin
                state_d = PWM_IDLE;
            end
        endcase
    end

    // State, counters and output registers. Reset discards any partial
    // measurement, so two fresh rises are needed before the next valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PWM_IDLE;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            duty_q       <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            duty_q       <= duty_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.duty_out   = duty_q;
    assign bus.period_out = period_q;
    assign bus.valid      = valid_q;
    assign bus.timeout    = timeout_q;
    assign bus.level      = sync_level;

endmodule
